// File: rtl/ram_wait_ctrl.sv
// Wait-state RAM controller: CPU-facing single-port 16-bit word array with
// a fixed number of inserted wait states per read or write access.
module ram_wait_ctrl #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        ExternalReset,
  input  logic        readMem,
  input  logic        wren,
  input  logic [15:0] address,
  input  logic [15:0] data,
  output logic [15:0] out,
  output logic        memDataReady,
  output logic        busy,
  output logic        addrErr
);

  localparam int unsigned DEPTH    = 1 << ADDR_W;
  localparam logic [3:0]  CNT_LAST = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [3:0]          wait_cnt;
  logic [15:0]         addr_q;
  logic [15:0]         data_q;
  logic                wr_q;
  logic                err_q;
  logic [15:0]         mem [DEPTH];

  logic                req_c;
  logic                take_c;
  logic                access_c;
  logic [15:0]         acc_addr_c;
  logic [15:0]         acc_data_c;
  logic                acc_wr_c;
  logic                oor_c;
  logic [ADDR_W-1:0]   acc_idx_c;

  // Request decode; a zero-wait build accesses straight from IDLE using live inputs
  assign req_c      = readMem | wren;
  assign take_c     = (state == IDLE) && req_c;
  assign access_c   = (WAIT_CYCLES == 0) ? take_c
                                         : ((state == WAIT) && (wait_cnt == CNT_LAST));
  assign acc_addr_c = (state == IDLE) ? address : addr_q;
  assign acc_data_c = (state == IDLE) ? data    : data_q;
  assign acc_wr_c   = (state == IDLE) ? wren    : wr_q;
  assign acc_idx_c  = acc_addr_c[ADDR_W-1:0];
  assign busy       = (state != IDLE);

  // Out-of-range detection on the address bits above the array
  generate
    if (ADDR_W < 16) begin : g_range
      assign oor_c = |acc_addr_c[15:ADDR_W];
    end else begin : g_full
      assign oor_c = 1'b0;
    end
  endgenerate

  // Array write on the edge entering DONE; contents survive reset
  always_ff @(posedge clk) begin
    if (access_c && acc_wr_c && !oor_c && !ExternalReset)
      mem[acc_idx_c] <= acc_data_c;
  end

  // Transaction FSM with registered read data and completion strobes
  always_ff @(posedge clk or posedge ExternalReset) begin
    if (ExternalReset) begin
      state        <= IDLE;
      wait_cnt     <= 4'd0;
      out          <= 16'h0000;
      memDataReady <= 1'b0;
      addrErr      <= 1'b0;
      addr_q       <= 16'h0000;
      data_q       <= 16'h0000;
      wr_q         <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      memDataReady <= (state == DONE);
      addrErr      <= (state == DONE) && err_q;

      if (access_c) begin
        err_q <= oor_c;
        if (!acc_wr_c)
          out <= oor_c ? 16'h0000 : mem[acc_idx_c];
      end

      case (state)
        IDLE: begin
          if (req_c) begin
            addr_q   <= address;
            data_q   <= data;
            wr_q     <= wren;
            wait_cnt <= 4'd0;
            state    <= (WAIT_CYCLES == 0) ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == CNT_LAST)
            state <= DONE;
          else
            wait_cnt <= wait_cnt + 4'd1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_wait_ctrl.sv
// Bench for ram_wait_ctrl: a WAIT_CYCLES=2/ADDR_W=8 instance and a
// WAIT_CYCLES=0/ADDR_W=16 instance, checked against a reference memory model.
module tb_ram_wait_ctrl;

  localparam int unsigned W = 2;

  logic        clk = 1'b0;
  logic        ExternalReset;
  logic        rd, wr;
  logic [15:0] addr, wdata, out;
  logic        mdr, busy, aerr;
  logic        rd0, wr0;
  logic [15:0] addr0, wdata0, out0;
  logic        mdr0, busy0, aerr0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] out;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] ref_mem [256];
  logic [15:0] ref0 [int];
  logic [15:0] ref_out  = 16'h0000;
  logic [15:0] ref_out0 = 16'h0000;

  always #5 clk = ~clk;

  ram_wait_ctrl #(.ADDR_W(8), .WAIT_CYCLES(W)) dut (
    .clk(clk), .ExternalReset(ExternalReset), .readMem(rd), .wren(wr),
    .address(addr), .data(wdata), .out(out), .memDataReady(mdr),
    .busy(busy), .addrErr(aerr)
  );

  ram_wait_ctrl #(.ADDR_W(16), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .ExternalReset(ExternalReset), .readMem(rd0), .wren(wr0),
    .address(addr0), .data(wdata0), .out(out0), .memDataReady(mdr0),
    .busy(busy0), .addrErr(aerr0)
  );

  task automatic checkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pop the oldest expected completion and compare it with the DUT outputs
  task automatic sb_check(input bit sel, input string tag);
    exp_t e;
    checkv({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checkv({tag, "_out"}, 32'(sel ? out0 : out), 32'(e.out));
      checkv({tag, "_err"}, 32'(sel ? aerr0 : aerr), 32'(e.err));
    end
  endtask

  // One transaction: model update, scoreboard push, drive, wait for strobe
  task automatic txn(input bit sel, input logic r, input logic w,
                     input logic [15:0] a, input logic [15:0] d,
                     input bit inject, input string tag);
    exp_t e;
    int   lat, busy_n, wc;
    bit   seen;
    logic oor;
    wc    = sel ? 0 : int'(W);
    oor   = sel ? 1'b0 : (a[15:8] != 8'h00);
    e.err = oor;
    if (w) begin
      if (!oor) begin
        if (sel) ref0[int'(a)] = d;
        else     ref_mem[a[7:0]] = d;
      end
      e.out = sel ? ref_out0 : ref_out;
    end else begin
      e.out = oor ? 16'h0000 : (sel ? ref0[int'(a)] : ref_mem[a[7:0]]);
      if (sel) ref_out0 = e.out;
      else     ref_out  = e.out;
    end
    sb.push_back(e);
    if (sel) begin rd0 = r; wr0 = w; addr0 = a; wdata0 = d; end
    else     begin rd  = r; wr  = w; addr  = a; wdata  = d; end
    @(posedge clk); #1;
    if (sel) begin rd0 = 1'b0; wr0 = 1'b0; end
    else     begin rd  = 1'b0; wr  = 1'b0; end
    lat = 0; busy_n = 0; seen = 0;
    while (!seen && lat < 40) begin
      if (inject && lat == 0) begin wr = 1'b1; addr = 16'h0006; wdata = 16'hDEAD; end
      if (inject && lat == 1) wr = 1'b0;
      if (sel ? busy0 : busy) busy_n++;
      if (sel ? mdr0 : mdr) seen = 1;
      else begin @(posedge clk); #1; lat++; end
    end
    checkv({tag, "_latency"}, 32'(lat), 32'(wc + 1));
    if (seen) sb_check(sel, tag);
    checkv({tag, "_busy_cycles"}, 32'(busy_n), 32'(wc + 1));
    @(posedge clk); #1;
    checkv({tag, "_strobe_width"}, 32'(sel ? mdr0 : mdr), 32'd0);
    checkv({tag, "_err_width"}, 32'(sel ? aerr0 : aerr), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, second, pulses, mdr_seen;
    ExternalReset = 1'b1;
    rd = 0; wr = 0; addr = 0; wdata = 0;
    rd0 = 0; wr0 = 0; addr0 = 0; wdata0 = 0;
    #2;
    checkv("rst_out",   32'(out),   32'h0);
    checkv("rst_mdr",   32'(mdr),   32'h0);
    checkv("rst_err",   32'(aerr),  32'h0);
    checkv("rst_busy",  32'(busy),  32'h0);
    checkv("rst0_out",  32'(out0),  32'h0);
    checkv("rst0_busy", 32'(busy0), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    ExternalReset = 1'b0;

    // Write then read back, plus seed values for later steps
    txn(0, 0, 1, 16'h0010, 16'hA5C3, 0, "wr_10");
    txn(0, 1, 0, 16'h0010, 16'h0000, 0, "rd_10");
    txn(0, 0, 1, 16'h0006, 16'h0606, 0, "wr_06");
    txn(0, 0, 1, 16'h0020, 16'h1111, 0, "wr_20");
    txn(0, 0, 1, 16'h0000, 16'h0BAD, 0, "wr_00");

    // Read+write together acts as write; a write request during WAIT is ignored
    txn(0, 1, 1, 16'h0005, 16'h1234, 1, "prio_05");
    txn(0, 1, 0, 16'h0005, 16'h0000, 0, "rd_05");
    txn(0, 1, 0, 16'h0006, 16'h0000, 0, "rd_06_ignored");

    // Out-of-range write and read
    txn(0, 0, 1, 16'h0100, 16'hFFFF, 0, "oor_wr");
    txn(0, 1, 0, 16'h0000, 16'h0000, 0, "rd_00_intact");
    txn(0, 1, 0, 16'h0100, 16'h0000, 0, "oor_rd");

    // Back-to-back reads with readMem held high
    txn(0, 0, 1, 16'h0001, 16'h1A1A, 0, "wr_01");
    txn(0, 0, 1, 16'h0002, 16'h2B2B, 0, "wr_02");
    sb.push_back('{out: ref_mem[1], err: 1'b0});
    sb.push_back('{out: ref_mem[2], err: 1'b0});
    ref_out = ref_mem[2];
    rd = 1'b1; addr = 16'h0001;
    @(posedge clk); #1;
    first = -1; second = -1; pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (i == 1) addr = 16'h0002;
      if (i == 4) rd = 1'b0;
      if (mdr) begin
        pulses++;
        if (first < 0) first = i; else if (second < 0) second = i;
        sb_check(0, "b2b");
      end
    end
    rd = 1'b0;
    checkv("b2b_pulses", 32'(pulses), 32'd2);
    checkv("b2b_first_latency", 32'(first), 32'(W + 1));
    checkv("b2b_gap", 32'(second - first - 1), 32'(W + 1));

    // Reset during WAIT of a write aborts it
    wr = 1'b1; addr = 16'h0020; wdata = 16'hBEEF;
    @(posedge clk); #1;
    wr = 1'b0;
    @(posedge clk); #3;
    checkv("abort_busy_before", 32'(busy), 32'd1);
    ExternalReset = 1'b1;
    #1;
    checkv("abort_busy", 32'(busy), 32'd0);
    checkv("abort_out",  32'(out),  32'h0);
    checkv("abort_mdr",  32'(mdr),  32'h0);
    checkv("abort_err",  32'(aerr), 32'h0);
    ref_out = 16'h0000; ref_out0 = 16'h0000;
    @(posedge clk); @(posedge clk); #1;
    ExternalReset = 1'b0;
    mdr_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (mdr) mdr_seen++;
    end
    checkv("abort_no_strobe", 32'(mdr_seen), 32'd0);
    txn(0, 1, 0, 16'h0020, 16'h0000, 0, "rd_20_kept");
    txn(0, 1, 0, 16'h0010, 16'h0000, 0, "rd_10_kept");

    // Zero-wait, full-address build
    txn(1, 0, 1, 16'hFF00, 16'h4242, 0, "z_wr_ff00");
    txn(1, 1, 0, 16'hFF00, 16'h0000, 0, "z_rd_ff00");
    txn(1, 1, 1, 16'h0003, 16'h7E57, 0, "z_prio_03");
    txn(1, 1, 0, 16'h0003, 16'h0000, 0, "z_rd_03");

    checkv("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
